// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Optional MDU_EARLY_EXIT_EN: multiplies leave RUN once the remaining multiplier magnitude is zero.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  wr_hi_i,
  input  logic                  wr_lo_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2*N:0]   acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic           neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           div_zero_q, div_zero_d;

  logic           is_div, is_signed, last_iter;
  logic [N-1:0]   abs_a, abs_b;
  logic [N:0]     rem_sh, diff;
  logic [2*N-1:0] prod;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign abs_a     = (is_signed && a_q[N-1]) ? -a_q : a_q;
  assign abs_b     = (is_signed && b_q[N-1]) ? -b_q : b_q;

  // Restoring divide step: shift in the next dividend bit, trial-subtract the divisor.
  assign rem_sh = {rem_q, quo_q[N-1]};
  assign diff   = rem_sh - {1'b0, dvsr_q};
  assign prod   = neg_res_q ? -acc_q[2*N-1:0] : acc_q[2*N-1:0];

`ifdef MDU_EARLY_EXIT_EN
  assign last_iter = (cnt_q == CW'(N-1)) || (!is_div && (mplier_q[N-1:1] == '0));
`else
  assign last_iter = (cnt_q == CW'(N-1));
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (wr_hi_i) hi_d = wr_data_i;
        if (wr_lo_i) lo_d = wr_data_i;
        if (start_i) begin
          op_d    = op_i;
          a_d     = operand_a_i;
          b_d     = operand_b_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_res_d = is_signed & (a_q[N-1] ^ b_q[N-1]);
        neg_rem_d = is_signed & a_q[N-1];
        cnt_d     = '0;
        if (is_div && (b_q == '0)) begin
          hi_d       = a_q;
          lo_d       = '1;
          div_zero_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          acc_d    = '0;
          mcand_d  = {{N{1'b0}}, abs_a};
          mplier_d = abs_b;
          rem_d    = '0;
          quo_d    = abs_a;
          dvsr_d   = abs_b;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div) begin
          if (!diff[N]) begin
            rem_d = diff[N-1:0];
            quo_d = {quo_q[N-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[N-1:0];
            quo_d = {quo_q[N-2:0], 1'b0};
          end
        end else begin
          if (mplier_q[0]) acc_d = acc_q + {1'b0, mcand_q};
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (last_iter) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div) begin
          lo_d = neg_res_q ? -quo_q : quo_q;
          hi_d = neg_rem_q ? -rem_q : rem_q;
        end else begin
          {hi_d, lo_d} = prod;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        div_zero_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = '0;
  logic [N-1:0]  operand_a_i = '0;
  logic [N-1:0]  operand_b_i = '0;
  logic          wr_hi_i = 1'b0;
  logic          wr_lo_i = 1'b0;
  logic [N-1:0]  wr_data_i = '0;
  logic          busy_o, done_o, div_zero_o;
  logic [N-1:0]  hi_o, lo_o;

  always #5 clk = ~clk;

  mult_div_unit #(.DATA_WIDTH(N)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .wr_hi_i(wr_hi_i), .wr_lo_i(wr_lo_i), .wr_data_i(wr_data_i),
    .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int bit_len(input logic [31:0] v);
    int k = 0;
    for (int i = 0; i < 32; i++) if (v[i]) k = i + 1;
    return k;
  endfunction

  // Reference: plain 64-bit arithmetic; start_cyc is the edge count seen when start_i is driven.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int start_cyc);
    exp_t        e;
    longint      sa, sb, p;
    logic [63:0] up;
    logic [31:0] mb;
    int          lat, k;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    lat  = N + 2;
    case (op)
      2'b00: begin up = 64'(a) * 64'(b); {e.hi, e.lo} = up; e.name = "multu"; end
      2'b01: begin p = sa * sb; {e.hi, e.lo} = p; e.name = "mult"; end
      2'b10: begin
        e.name = "divu";
        if (b != 0) begin e.lo = a / b; e.hi = a % b; end
      end
      default: begin
        e.name = "div";
        if (b != 0) begin p = sa / sb; e.lo = p[31:0]; p = sa % sb; e.hi = p[31:0]; end
      end
    endcase
    if (op[1] && b == 0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; lat = 1;
    end
`ifdef MDU_EARLY_EXIT_EN
    if (!op[1]) begin
      mb  = (op[0] && b[31]) ? -b : b;
      k   = bit_len(mb);
      if (k == 0) k = 1;
      lat = k + 2;
    end
`endif
    e.cyc = start_cyc + 1 + lat;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset && done_o) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_hi"}, 64'(hi_o), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo_o), 64'(e.lo));
        check({e.name, "_div_zero"}, 64'(div_zero_o), 64'(e.dz));
        check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic whi, input logic [31:0] wdata, output int s);
    @(negedge clk);
    op_i = op; operand_a_i = a; operand_b_i = b; start_i = 1'b1;
    wr_hi_i = whi; wr_data_i = wdata;
    s = cyc;
    exp_q.push_back(model(op, a, b, cyc));
    @(negedge clk);
    start_i = 1'b0; wr_hi_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((busy_o || exp_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy_o || exp_q.size() != 0) begin
      check({name, "_timeout"}, 64'd1, 64'd0);
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int s, lat, bad;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_hi_lo", {hi_o, lo_o}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_done_dz", {62'd0, done_o, div_zero_o}, 64'd0);

    // MULTU 0xFFFFFFFF*2 with busy window over every edge
    issue(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, s);
    lat = exp_q[0].cyc - s - 1;
    bad = 0;
    for (int j = 0; j <= lat + 1; j++) begin
      if (busy_o !== (j <= lat)) bad++;
      @(negedge clk);
    end
    check("busy_window", 64'(bad), 64'd0);
    wait_idle("t1");

    issue(2'b01, -32'd3, 32'd5, 1'b0, 32'd0, s);            wait_idle("t2a");
    issue(2'b11, -32'd7, 32'd2, 1'b0, 32'd0, s);            wait_idle("t2b");
    issue(2'b10, 32'd7, 32'd0, 1'b0, 32'd0, s);             wait_idle("t3");
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, s); wait_idle("t4");
    issue(2'b00, 32'd3, 32'd5, 1'b0, 32'd0, s);             wait_idle("t6");

    repeat (5) @(negedge clk);
    check("hold_hi_lo", {hi_o, lo_o}, {32'd0, 32'd15});

    // MTHI / MTLO in IDLE
    wr_hi_i = 1'b1; wr_data_i = 32'h1234_ABCD;
    @(negedge clk);
    wr_hi_i = 1'b0;
    check("mthi_idle", 64'(hi_o), 64'h1234_ABCD);
    wr_lo_i = 1'b1; wr_data_i = 32'h0F0F_5555;
    @(negedge clk);
    wr_lo_i = 1'b0;
    check("mtlo_idle", {hi_o, lo_o}, {32'h1234_ABCD, 32'h0F0F_5555});

    // MTHI together with start: applied, then overwritten by the result
    issue(2'b00, 32'd6, 32'd7, 1'b1, 32'hA5A5_A5A5, s);
    check("mthi_with_start", 64'(hi_o), 64'hA5A5_A5A5);
    wait_idle("wr_start");

    // Busy-time start and MTHI are ignored
    issue(2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'd0, s);
    while (cyc < s + 5) @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; operand_a_i = 32'd99; operand_b_i = 32'd4;
    wr_hi_i = 1'b1; wr_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    start_i = 1'b0; wr_hi_i = 1'b0;
    wait_idle("busy_ignore");
    repeat (4) @(negedge clk);
    check("no_requeued_op", 64'(busy_o), 64'd0);

    // Reset mid-operation aborts with no done pulse
    issue(2'b10, 32'hCAFE_0000, 32'd3, 1'b0, 32'd0, s);
    while (cyc < s + 10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_hi_lo", {hi_o, lo_o}, 64'd0);
    exp_q.delete();
    done_seen = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_seen), 64'd0);

    // Randomized operations with ignored noise while busy
    for (int i = 0; i < 250; i++) begin
      issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 1'b0, 32'd0, s);
      for (int t = 0; t < 60 && busy_o; t++) begin
        if (busy_o && !done_o) begin
          wr_hi_i = ($urandom_range(0, 3) == 0);
          wr_lo_i = ($urandom_range(0, 3) == 0);
          start_i = ($urandom_range(0, 3) == 0);
          wr_data_i = $urandom; operand_a_i = $urandom; operand_b_i = $urandom;
        end else begin
          wr_hi_i = 1'b0; wr_lo_i = 1'b0; start_i = 1'b0;
        end
        @(negedge clk);
      end
      wr_hi_i = 1'b0; wr_lo_i = 1'b0; start_i = 1'b0;
      wait_idle("random");
      if ($urandom_range(0, 9) == 0) begin
        d = $urandom;
        wr_lo_i = 1'b1; wr_data_i = d;
        @(negedge clk);
        wr_lo_i = 1'b0;
        check("random_mtlo", 64'(lo_o), 64'(d));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
